// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared opcodes, FSM state encodings and defaults for the
//                EX-stage multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam logic MD_MODE_MUL = 1'b0;
    localparam logic MD_MODE_DIV = 1'b1;

    // Multi-cycle ops are exactly the ones with op[2] clear.
    function automatic logic is_muldiv(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_md_step.sv
`default_nettype none
// ============================================================================
//  Module      : md_step
//  Description : One radix-2 iteration: shift-add multiply or restoring divide.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               mode,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               qbit
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_upper;
    logic [WIDTH+1:0] w_diff;

    always_comb begin
        w_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        w_upper  = acc[2*WIDTH-1:WIDTH-1];
        w_diff   = {1'b0, w_upper} - {2'b00, operand};
        qbit     = 1'b0;
        acc_next = {w_sum, acc[WIDTH-1:1]};
        if (mode == MD_MODE_DIV) begin
            qbit = ~w_diff[WIDTH+1];
            // The shifted-in quotient bit slot is left zero; the caller inserts qbit.
            if (qbit) begin
                acc_next = {w_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else begin
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Multi-cycle mult/div unit owning the architectural HI/LO pair.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH    = MD_WIDTH,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int             CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]  c_last = CW'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opb;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_signed;
    logic               w_div_op;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [2*WIDTH-1:0] w_step_acc;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_run_acc;
    logic               w_fast_one;
    logic               w_last_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    assign w_accept = start && is_muldiv(op);
    assign w_signed = (op == MD_MULT) || (op == MD_DIV);
    assign w_div_op = (op == MD_DIV) || (op == MD_DIVU);
    assign w_sa     = w_signed & a[WIDTH-1];
    assign w_sb     = w_signed & b[WIDTH-1];
    assign w_abs_a  = w_sa ? -a : a;
    assign w_abs_b  = w_sb ? -b : b;

    md_step #(.WIDTH(WIDTH)) u_step (
        .acc      (r_acc),
        .operand  (r_opb),
        .mode     (r_is_div ? MD_MODE_DIV : MD_MODE_MUL),
        .acc_next (w_step_acc),
        .qbit     (w_qbit)
    );

    generate
        if (FAST_MUL) begin : g_fast_mul
            logic [2*WIDTH-1:0] w_fast_prod;
            assign w_fast_prod = {{WIDTH{1'b0}}, r_acc[WIDTH-1:0]} * {{WIDTH{1'b0}}, r_opb};
            assign w_fast_one  = ~r_is_div;
            assign w_run_acc   = r_is_div ? {w_step_acc[2*WIDTH-1:1], w_qbit} : w_fast_prod;
        end else begin : g_serial_mul
            assign w_fast_one  = 1'b0;
            assign w_run_acc   = r_is_div ? {w_step_acc[2*WIDTH-1:1], w_qbit} : w_step_acc;
        end
    endgenerate

    assign w_last_step = (r_count == c_last) || w_fast_one;
    assign w_prod      = r_neg_q ? -r_acc : r_acc;
    assign w_quot      = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem       = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)    w_state_next = ST_RUN;
            ST_RUN:  if (w_last_step) w_state_next = ST_FIX;
            ST_FIX:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != ST_IDLE);
        done = r_done;
        hi   = r_hi;
        lo   = r_lo;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= (r_state == ST_FIX);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                                r_count  <= '0;
                                r_is_div <= w_div_op;
                                r_opb    <= w_div_op ? w_abs_b : w_abs_a;
                                r_acc    <= {{WIDTH{1'b0}}, (w_div_op ? w_abs_a : w_abs_b)};
                                // Divide-by-zero keeps the all-ones quotient unsigned-looking.
                                r_neg_q  <= (w_sa ^ w_sb) & ~(w_div_op && (b == '0));
                                r_neg_r  <= w_sa;
                            end
                            MD_MTHI: r_hi <= a;
                            MD_MTLO: r_lo <= a;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    r_acc   <= w_run_acc;
                    r_count <= r_count + 1'b1;
                end
                ST_FIX: begin
                    if (r_is_div) begin
                        r_lo <= w_quot;
                        r_hi <= w_rem;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
